// File: rtl/sprite_draw_ctrl.sv
// Walks one 16x16 sprite through the loadImage ROM and emits clipped,
// latency-aligned VGA pixel writes.
module sprite_draw_ctrl #(
    parameter int ROM_LAT   = 2,
    parameter bit TRANSP_EN = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] x_in,
    input  logic [7:0] y_in,
    input  logic [1:0] key_in,
    input  logic [2:0] frame_in,
    output logic       busy,
    output logic       done,
    output logic [3:0] img_i,
    output logic [5:0] img_j,
    output logic [2:0] img_id,
    output logic [1:0] img_id2,
    input  logic [2:0] img_colour,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    localparam int CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t                    state_q, state_d;
    logic [3:0]                col_q, col_d, row_q, row_d;
    logic [7:0]                x_lat_q, x_lat_d, y_lat_q, y_lat_d;
    logic [2:0]                id_q, id_d;
    logic [1:0]                id2_q, id2_d;
    logic [CW-1:0]             drain_cnt_q, drain_cnt_d;
    logic [ROM_LAT-1:0]        pv_q, pv_d;
    logic [ROM_LAT-1:0][3:0]   pc_q, pc_d, pr_q, pr_d;
    logic [7:0]                vx_q, vx_d;
    logic [6:0]                vy_q, vy_d;
    logic [2:0]                vcol_q, vcol_d;
    logic                      vplot_q, vplot_d;
    logic [8:0]                px, py;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        x_lat_d     = x_lat_q;
        y_lat_d     = y_lat_q;
        id_d        = id_q;
        id2_d       = id2_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_lat_d = x_in;
                    y_lat_d = y_in;
                    id_d    = frame_in;
                    id2_d   = key_in;
                    col_d   = 4'd0;
                    row_d   = 4'd0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                col_d = col_q + 4'd1;
                if (col_q == 4'd15) begin
                    row_d = row_q + 4'd1;
                end
                if (col_q == 4'd15 && row_q == 4'd15) begin
                    state_d     = DRAIN;
                    drain_cnt_d = CW'(ROM_LAT - 1);
                end
            end
            DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address pipe: tags each ROM read so the colour returning ROM_LAT
    // cycles later is paired with the right pixel coordinates.
    always_comb begin
        pv_d    = '0;
        pc_d    = '0;
        pr_d    = '0;
        pv_d[0] = (state_q == SCAN);
        pc_d[0] = col_q;
        pr_d[0] = row_q;
        for (int i = 1; i < ROM_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pc_d[i] = pc_q[i-1];
            pr_d[i] = pr_q[i-1];
        end
    end

    always_comb begin
        px      = {1'b0, x_lat_q} + {5'd0, pc_q[ROM_LAT-1]};
        py      = {1'b0, y_lat_q} + {5'd0, pr_q[ROM_LAT-1]};
        vplot_d = pv_q[ROM_LAT-1] && (px < 9'd160) && (py < 9'd120) &&
                  !(TRANSP_EN && (img_colour == 3'b000));
        vx_d    = vx_q;
        vy_d    = vy_q;
        vcol_d  = vcol_q;
        if (vplot_d) begin
            vx_d   = px[7:0];
            vy_d   = py[6:0];
            vcol_d = img_colour;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            x_lat_q     <= '0;
            y_lat_q     <= '0;
            id_q        <= '0;
            id2_q       <= '0;
            drain_cnt_q <= '0;
            pv_q        <= '0;
            pc_q        <= '0;
            pr_q        <= '0;
            vx_q        <= '0;
            vy_q        <= '0;
            vcol_q      <= '0;
            vplot_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            x_lat_q     <= x_lat_d;
            y_lat_q     <= y_lat_d;
            id_q        <= id_d;
            id2_q       <= id2_d;
            drain_cnt_q <= drain_cnt_d;
            pv_q        <= pv_d;
            pc_q        <= pc_d;
            pr_q        <= pr_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
            vcol_q      <= vcol_d;
            vplot_q     <= vplot_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign img_i      = col_q;
    assign img_j      = {2'b00, row_q};
    assign img_id     = id_q;
    assign img_id2    = id2_q;
    assign vga_x      = vx_q;
    assign vga_y      = vy_q;
    assign vga_colour = vcol_q;
    assign vga_plot   = vplot_q;

endmodule

// File: tb/tb_sprite_draw_ctrl.sv
// Scoreboard bench for sprite_draw_ctrl: stimulus queues expected plots and
// done pulses; a negedge monitor pops and compares them.
module tb_sprite_draw_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] x_in = '0, y_in = '0;
    logic [1:0] key_in = '0;
    logic [2:0] frame_in = '0;
    logic [2:0] img_colour = '0;
    logic [2:0] rom_s1 = '0;

    logic       busy, done, vga_plot;
    logic [3:0] img_i;
    logic [5:0] img_j;
    logic [2:0] img_id, vga_colour;
    logic [1:0] img_id2;
    logic [7:0] vga_x;
    logic [6:0] vga_y;

    logic       busy_t0, done_t0, vga_plot_t0;
    logic [3:0] img_i_t0;
    logic [5:0] img_j_t0;
    logic [2:0] img_id_t0, vga_colour_t0;
    logic [1:0] img_id2_t0;
    logic [7:0] vga_x_t0;
    logic [6:0] vga_y_t0;

    sprite_draw_ctrl #(.ROM_LAT(2), .TRANSP_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
        .key_in(key_in), .frame_in(frame_in), .busy(busy), .done(done),
        .img_i(img_i), .img_j(img_j), .img_id(img_id), .img_id2(img_id2),
        .img_colour(img_colour), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot));

    sprite_draw_ctrl #(.ROM_LAT(2), .TRANSP_EN(1'b0)) dut_t0 (
        .clock(clock), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
        .key_in(key_in), .frame_in(frame_in), .busy(busy_t0), .done(done_t0),
        .img_i(img_i_t0), .img_j(img_j_t0), .img_id(img_id_t0), .img_id2(img_id2_t0),
        .img_colour(img_colour), .vga_x(vga_x_t0), .vga_y(vga_y_t0),
        .vga_colour(vga_colour_t0), .vga_plot(vga_plot_t0));

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int mode = 0;

    function automatic logic [2:0] rom_fn(input int m, input logic [3:0] c);
        case (m)
            0:       return 3'b101;
            1:       return 3'b111;
            2:       return c[0] ? 3'b010 : 3'b000;
            default: return c[2:0];
        endcase
    endfunction

    // Two-register ROM model: colour appears two cycles after the address.
    always @(posedge clock) begin
        rom_s1     <= rom_fn(mode, img_i);
        img_colour <= rom_s1;
    end

    typedef struct {int x; int y; int c; int cyc;} exp_t;
    exp_t q[$];
    int   done_q[$];
    exp_t e;
    int   de;
    int   checks = 0, passes = 0;
    int   nplot = 0, nplot0 = 0;
    int   s = 0;

    always @(negedge clock) begin
        if (vga_plot_t0 === 1'b1) nplot0++;
        if (vga_plot === 1'b1) begin
            nplot++;
            checks++;
            if (q.size() == 0) begin
                $display("FAIL plot_unexpected got x=%0d y=%0d c=%0d cyc=%0d want none",
                         vga_x, vga_y, vga_colour, cyc);
            end else begin
                e = q.pop_front();
                if (vga_x == e.x && vga_y == e.y && vga_colour == e.c && cyc == e.cyc)
                    passes++;
                else
                    $display("FAIL plot got x=%0d y=%0d c=%0d cyc=%0d want x=%0d y=%0d c=%0d cyc=%0d",
                             vga_x, vga_y, vga_colour, cyc, e.x, e.y, e.c, e.cyc);
            end
        end
        if (done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                $display("FAIL done_unexpected got cyc=%0d want none", cyc);
            end else begin
                de = done_q.pop_front();
                if (cyc == de) passes++;
                else $display("FAIL done_cycle got %0d want %0d", cyc, de);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s got=%0d want=%0d", name, got, want);
    endtask

    task automatic push_draw(input int x, input int y, input int m, input int s0);
        int col, row, c, px, py;
        for (int k = 0; k < 256; k++) begin
            col = k % 16;
            row = k / 16;
            c   = int'(rom_fn(m, 4'(col)));
            px  = x + col;
            py  = y + row;
            if (px < 160 && py < 120 && c != 0)
                q.push_back('{px % 256, py % 128, c, s0 + k + 4});
        end
        done_q.push_back(s0 + 259);
    endtask

    task automatic goto_cycle(input int s0, input int n);
        do @(negedge clock); while (cyc - s0 < n);
    endtask

    // Called at a negedge with the DUT idle; returns in cycle 1.
    task automatic launch(input int x, input int y, input int k, input int f,
                          input int m, output int s0);
        mode     = m;
        x_in     = 8'(x);
        y_in     = 8'(y);
        key_in   = 2'(k);
        frame_in = 3'(f);
        start    = 1'b1;
        s0       = cyc;
        nplot    = 0;
        nplot0   = 0;
        push_draw(x, y, m, s0);
        @(posedge clock);
        #1;
        start    = 1'b0;
        x_in     = 8'($urandom);
        y_in     = 8'($urandom);
        key_in   = 2'($urandom);
        frame_in = 3'($urandom);
        chk("busy_cycle1", int'(busy), 1);
    endtask

    task automatic finish_draw(input int s0, input string name, input int want_plots,
                               input int k, input int f);
        goto_cycle(s0, 200);
        chk({name, "_img_id2_mid"}, int'(img_id2), k);
        chk({name, "_img_id_mid"}, int'(img_id), f);
        goto_cycle(s0, 259);
        chk({name, "_done_259"}, int'(done), 1);
        chk({name, "_busy_259"}, int'(busy), 1);
        goto_cycle(s0, 260);
        chk({name, "_busy_260"}, int'(busy), 0);
        chk({name, "_plots"}, nplot, want_plots);
        chk({name, "_plot_q_empty"}, q.size(), 0);
        chk({name, "_done_q_empty"}, done_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_plot", int'(vga_plot), 0);
        chk("rst_vga_x", int'(vga_x), 0);
        chk("rst_vga_y", int'(vga_y), 0);
        chk("rst_vga_colour", int'(vga_colour), 0);
        chk("rst_img_i", int'(img_i), 0);
        chk("rst_img_j", int'(img_j), 0);
        chk("rst_img_id", int'(img_id), 0);
        chk("rst_img_id2", int'(img_id2), 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // basic draw
        launch(20, 30, 1, 2, 0, s);
        goto_cycle(s, 4);
        chk("basic_first_plot", int'(vga_plot), 1);
        chk("basic_first_x", int'(vga_x), 20);
        chk("basic_first_y", int'(vga_y), 30);
        finish_draw(s, "basic", 256, 1, 2);
        chk("basic_last_x", int'(vga_x), 35);
        chk("basic_last_y", int'(vga_y), 45);

        // clipping
        launch(150, 110, 3, 0, 1, s);
        finish_draw(s, "clip", 100, 3, 0);

        // transparency, with the non-transparent instance alongside
        launch(40, 20, 2, 5, 2, s);
        finish_draw(s, "transp", 128, 2, 5);
        chk("transp_off_plots", nplot0, 256);

        // start while busy and in DONE
        launch(20, 30, 0, 1, 0, s);
        goto_cycle(s, 50);
        start = 1'b1; x_in = 8'd0; y_in = 8'd0;
        @(posedge clock); #1; start = 1'b0;
        goto_cycle(s, 259);
        chk("busy_done_259", int'(done), 1);
        start = 1'b1; x_in = 8'd0; y_in = 8'd0;
        @(posedge clock); #1; start = 1'b0;
        goto_cycle(s, 260);
        chk("busy_idle_260", int'(busy), 0);
        chk("busy_first_plots", nplot, 256);
        chk("busy_done_q_empty", done_q.size(), 0);
        launch(0, 0, 0, 0, 0, s);
        finish_draw(s, "restart", 256, 0, 0);

        // reset mid-draw
        launch(60, 40, 1, 3, 0, s);
        goto_cycle(s, 100);
        #1;
        reset = 1'b0;
        q.delete();
        done_q.delete();
        #1;
        chk("midrst_plot", int'(vga_plot), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        chk("midrst_busy_after", int'(busy), 0);
        chk("midrst_done_after", int'(done), 0);
        launch(60, 40, 1, 3, 0, s);
        finish_draw(s, "after_rst", 256, 1, 3);

        // latency alignment: colour = col[2:0], col 0 and 8 are transparent
        launch(10, 5, 2, 7, 3, s);
        finish_draw(s, "align", 224, 2, 7);
        chk("align_off_plots", nplot0, 256);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
